// File: rtl/serial_adder.sv
// Multi-cycle adder/subtractor: DIGIT bits per clock through a full-adder chain with a registered carry.
// Optional overflow/zero flags are built when SERIAL_ADDER_FLAGS_EN is defined; otherwise both outputs are tied to 0.
module serial_adder #(
    parameter int N     = 32,
    parameter int DIGIT = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] sum,
    output logic         c_out,
    output logic         overflow,
    output logic         zero
);

    localparam int STEPS = N / DIGIT;
    localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q;
    logic            carry_q;
    logic [N-1:0]    a_q, b_q, sum_q;
    logic            c_out_q;

    logic [DIGIT-1:0] a_dig, b_dig, dig_sum;
    logic             dig_carry;
    logic [N-1:0]     sum_shift;
    logic             accept, step, last_step;

    // Operands are shifted right each step, so the current digit is always the low DIGIT bits.
    assign a_dig = a_q[DIGIT-1:0];
    assign b_dig = b_q[DIGIT-1:0];

`ifdef SERIAL_ADDER_FLAGS_EN
    logic msb_carry_in;
`endif

    always_comb begin : adder_chain
        logic c;
        // NOTE: every variable driven here gets a value before any branch, so no latch is inferred.
        c         = carry_q;
        dig_sum   = '0;
`ifdef SERIAL_ADDER_FLAGS_EN
        msb_carry_in = 1'b0;
`endif
        for (int i = 0; i < DIGIT; i++) begin
`ifdef SERIAL_ADDER_FLAGS_EN
            if (i == DIGIT - 1) msb_carry_in = c;
`endif
            dig_sum[i] = a_dig[i] ^ b_dig[i] ^ c;
            c          = (a_dig[i] & b_dig[i]) | (c & (a_dig[i] ^ b_dig[i]));
        end
        dig_carry = c;
    end

    // The result enters from the top; after STEPS digits the low digit has reached bit 0.
    generate
        if (DIGIT == N) begin : g_single_step
            assign sum_shift = dig_sum;
        end else begin : g_multi_step
            assign sum_shift = {dig_sum, sum_q[N-1:DIGIT]};
        end
    endgenerate

    assign accept    = (state_q == IDLE) && in_valid;
    assign step      = (state_q == BUSY);
    assign last_step = step && (cnt_q == LAST);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid)  state_d = BUSY;
            BUSY:    if (cnt_q == LAST) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            c_out_q <= 1'b0;
        end else if (accept) begin
            // Subtraction is a + ~b + 1: invert b once here and seed the carry with sub.
            a_q     <= a;
            b_q     <= sub ? ~b : b;
            carry_q <= sub;
            cnt_q   <= '0;
        end else if (step) begin
            a_q     <= a_q >> DIGIT;
            b_q     <= b_q >> DIGIT;
            carry_q <= dig_carry;
            cnt_q   <= cnt_q + 1'b1;
            sum_q   <= sum_shift;
            if (last_step) c_out_q <= dig_carry;
        end
    end

`ifdef SERIAL_ADDER_FLAGS_EN
    logic ovf_q, zero_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
        end else if (last_step) begin
            // Signed overflow: carry into the MSB differs from carry out of it.
            ovf_q  <= msb_carry_in ^ dig_carry;
            zero_q <= (sum_shift == '0);
        end
    end

    assign overflow = ovf_q;
    assign zero     = zero_q;
`else
    assign overflow = 1'b0;
    assign zero     = 1'b0;
`endif

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign sum       = sum_q;
    assign c_out     = c_out_q;

endmodule
